// File: rtl/dm_apb_pkg.sv
// Shared definitions for the Debug Module APB arbiter slice.
//  - arb_state_e : APB sequencing FSM states (IDLE / SETUP / ACCESS)
//  - DM_*        : Debug Module register indices (addr[7:0])
//  - idx_to_oh   : requester index -> one-hot helper
package dm_apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } arb_state_e;

  localparam logic [7:0] DM_DATA0      = 8'h04;
  localparam logic [7:0] DM_DATA1      = 8'h05;
  localparam logic [7:0] DM_DATA2      = 8'h06;
  localparam logic [7:0] DM_DATA3      = 8'h07;
  localparam logic [7:0] DM_DMCONTROL  = 8'h10;
  localparam logic [7:0] DM_DMSTATUS   = 8'h11;
  localparam logic [7:0] DM_HARTINFO   = 8'h12;
  localparam logic [7:0] DM_ABSTRACTCS = 8'h16;
  localparam logic [7:0] DM_COMMAND    = 8'h17;

  function automatic logic [1:0] idx_to_oh(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dm_rr_arbiter2.sv
// Two-way round-robin grant selection (purely combinational).
// Ports:
//  valid[1:0]    in  : requester request lines
//  last_grant    in  : index of the requester served most recently
//  grant_oh[1:0] out : one-hot grant, zero when no request
//  grant_idx     out : granted index (meaningful only when grant_oh != 0)
module dm_rr_arbiter2
  import dm_apb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant_oh,
  output logic       grant_idx
);

  always_comb begin
    // On a tie the requester not served last wins; otherwise the lone requester.
    grant_idx = (valid == 2'b11) ? ~last_grant : ~valid[0];
    grant_oh  = (|valid) ? idx_to_oh(grant_idx) : '0;
  end

endmodule

// File: rtl/dm_apb_arbiter.sv
// Shares the Debug Module APB slave between the JTAG DTM (req 0) and the
// system-side debug host (req 1). Round-robin grant, one transfer in flight,
// response routed back to the owning requester.
// Ports:
//  clock, resetn (async, active-low)
//  req_valid/req_write/req_addr/req_wdata in, req_ready out (comb accept pulse)
//  rsp_valid (one-hot pulse), rsp_rdata, rsp_err out (registered)
//  psel/penable/pwrite/paddr/pwdata out, prdata/pready in (APB master side)
// Optional feature: define DM_ARB_TIMEOUT_EN to abort an ACCESS phase after
// TIMEOUT_CYCLES cycles with pready low (completes with rsp_err=1).
module dm_apb_arbiter
  import dm_apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [1:0]              req_valid,
  input  logic [1:0]              req_write,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              req_ready,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready
);

  arb_state_e            state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_grant_q, last_grant_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [1:0]            rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  logic [1:0] grant_oh;
  logic       grant_idx;

`ifdef DM_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            rsp_err_q, rsp_err_d;
`endif

  dm_rr_arbiter2 u_rr (
    .valid      (req_valid),
    .last_grant (last_grant_q),
    .grant_oh   (grant_oh),
    .grant_idx  (grant_idx)
  );

  assign req_ready = (state_q == ST_IDLE) ? grant_oh : '0;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    rsp_valid_d  = '0;
    rsp_rdata_d  = rsp_rdata_q;
`ifdef DM_ARB_TIMEOUT_EN
    to_cnt_d     = to_cnt_q;
    rsp_err_d    = rsp_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          owner_d   = grant_idx;
          pwrite_d  = req_write[grant_idx];
          paddr_d   = grant_idx ? req_addr[ADDR_WIDTH +: ADDR_WIDTH]
                                : req_addr[0 +: ADDR_WIDTH];
          pwdata_d  = grant_idx ? req_wdata[DATA_WIDTH +: DATA_WIDTH]
                                : req_wdata[0 +: DATA_WIDTH];
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = ST_SETUP;
`ifdef DM_ARB_TIMEOUT_EN
          to_cnt_d  = '0;
`endif
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pready) begin
          rsp_rdata_d  = pwrite_q ? '0 : prdata;
          rsp_valid_d  = idx_to_oh(owner_q);
          psel_d       = 1'b0;
          penable_d    = 1'b0;
          last_grant_d = owner_q;
          state_d      = ST_IDLE;
`ifdef DM_ARB_TIMEOUT_EN
          rsp_err_d    = 1'b0;
        end else if (to_cnt_q == TO_LAST) begin
          rsp_rdata_d  = '0;
          rsp_valid_d  = idx_to_oh(owner_q);
          rsp_err_d    = 1'b1;
          psel_d       = 1'b0;
          penable_d    = 1'b0;
          last_grant_d = owner_q;
          state_d      = ST_IDLE;
        end else begin
          to_cnt_d     = to_cnt_q + 1'b1;
`endif
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
`ifdef DM_ARB_TIMEOUT_EN
      to_cnt_q     <= '0;
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
`ifdef DM_ARB_TIMEOUT_EN
      to_cnt_q     <= to_cnt_d;
      rsp_err_q    <= rsp_err_d;
`endif
    end
  end

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
`ifdef DM_ARB_TIMEOUT_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_dm_apb_arbiter.sv
// Self-checking bench for dm_apb_arbiter: directed steps plus a scoreboard
// of expected responses and APB phases, filled on each observed accept.
module tb_dm_apb_arbiter;
  import dm_apb_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic            clock = 1'b0;
  logic            resetn;
  logic [1:0]      req_valid, req_write, req_ready, rsp_valid;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, pwdata, prdata;
  logic            rsp_err, psel, penable, pwrite, pready;
  logic [AW-1:0]   paddr;

  always #5 clock = ~clock;

  dm_apb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .resetn(resetn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready)
  );

  // Read-only DM slave model; junk on the bus whenever no read ACCESS is active.
  function automatic logic [31:0] slv_data(input logic [7:0] a);
    if (a == DM_DMSTATUS) return 32'h0040_0C82;
    return {8'hA5, a, ~a, 8'h3C};
  endfunction
  assign prdata = (psel && penable && !pwrite) ? slv_data(paddr[7:0]) : 32'hBAD0_BAD0;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  owner_oh;
    logic        w;
    logic [31:0] addr, wdata, rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];
  logic model_last;
  bit   expect_to;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: checks grant choice, APB phase payload and responses.
  always @(negedge clock) begin
    exp_t e;
    logic g;
    if (resetn === 1'b1) begin
      if (rsp_valid !== 2'b00) begin
        if (sb.size() == 0) chk("rsp_unexpected", {62'd0, rsp_valid}, 64'd0);
        else begin
          e = sb.pop_front();
          chk("rsp_owner", {62'd0, rsp_valid}, {62'd0, e.owner_oh});
          chk("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, e.rdata});
          chk("rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
        end
      end
      if (psel === 1'b1) begin
        if (sb.size() == 0) chk("apb_sel_no_txn", {63'd0, psel}, 64'd0);
        else begin
          chk("apb_pwrite", {63'd0, pwrite}, {63'd0, sb[0].w});
          chk("apb_paddr", {32'd0, paddr}, {32'd0, sb[0].addr});
          chk("apb_pwdata", {32'd0, pwdata}, {32'd0, sb[0].wdata});
        end
      end
      if (req_ready !== 2'b00) begin
        g = (req_valid == 2'b11) ? ~model_last : ~req_valid[0];
        chk("grant", {62'd0, req_ready}, {62'd0, (g ? 2'b10 : 2'b01)});
        model_last = g;
        e.owner_oh = g ? 2'b10 : 2'b01;
        e.w        = req_write[g];
        e.addr     = req_addr[g*AW +: AW];
        e.wdata    = req_wdata[g*DW +: DW];
        e.err      = expect_to;
        e.rdata    = (e.w || expect_to) ? 32'd0 : slv_data(e.addr[7:0]);
        sb.push_back(e);
      end
    end
  end

  task automatic set_req(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
    req_write[i]         = w;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
    req_valid[i]         = 1'b1;
  endtask

  task automatic await_accept(input int i, output int unsigned acc);
    bit ok = 0;
    acc = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clock);
      if (req_ready[i]) begin ok = 1; acc = cyc; break; end
    end
    chk("accept_wait", {63'd0, ok}, 64'd1);
    @(posedge clock); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clock); #1;
      if (sb.size() == 0) begin ok = 1; break; end
    end
    chk("drain", {63'd0, ok}, 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t, prev, acc;
    bit got;
    int idx;
    logic [7:0] rr_addr [4];
    rr_addr[0] = DM_ABSTRACTCS; rr_addr[1] = DM_COMMAND;
    rr_addr[2] = DM_DATA1;      rr_addr[3] = DM_DATA3;

    resetn = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    pready = 1'b1; model_last = 1'b1; expect_to = 0;
    repeat (2) @(negedge clock);
    chk("rst_psel", {63'd0, psel}, 64'd0);
    chk("rst_penable", {63'd0, penable}, 64'd0);
    chk("rst_pwrite", {63'd0, pwrite}, 64'd0);
    chk("rst_paddr", {32'd0, paddr}, 64'd0);
    chk("rst_pwdata", {32'd0, pwdata}, 64'd0);
    chk("rst_rsp_valid", {62'd0, rsp_valid}, 64'd0);
    chk("rst_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
    chk("rst_rsp_err", {63'd0, rsp_err}, 64'd0);
    chk("rst_req_ready", {62'd0, req_ready}, 64'd0);
    @(posedge clock); #1 resetn = 1'b1;

    // Contention from reset: req0, req1, req0, req1, back-to-back.
    set_req(0, 1'b0, {24'd0, DM_DMSTATUS}, 32'h1111_0000);
    set_req(1, 1'b0, {24'd0, DM_HARTINFO}, 32'h2222_0000);
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      got = 0;
      for (int n = 0; n < 10; n++) begin
        @(negedge clock);
        if (req_ready != 2'b00) begin got = 1; break; end
      end
      chk("rr_accept_seen", {63'd0, got}, 64'd1);
      chk("rr_order", {62'd0, req_ready}, (k % 2 == 1) ? 64'd2 : 64'd1);
      if (k > 0) chk("rr_gap", 64'(cyc - prev), 64'd3);
      prev = cyc;
      idx = req_ready[1] ? 1 : 0;
      @(posedge clock); #1;
      if (k == 3) req_valid = 2'b00;
      else set_req(idx, 1'b0, {24'd0, rr_addr[k]}, 32'h3333_0000 + k);
    end
    wait_drain();

    // Single read: latency and phase timing.
    @(posedge clock); #1 set_req(0, 1'b0, {24'd0, DM_DMSTATUS}, 32'h0);
    @(negedge clock);
    chk("t1_ready", {62'd0, req_ready}, 64'd1);
    chk("t1_psel_accept", {63'd0, psel}, 64'd0);
    t = cyc;
    @(posedge clock); #1 req_valid[0] = 1'b0;
    @(negedge clock);
    chk("t1_setup_psel", {63'd0, psel}, 64'd1);
    chk("t1_setup_penable", {63'd0, penable}, 64'd0);
    @(negedge clock);
    chk("t1_access_psel", {63'd0, psel}, 64'd1);
    chk("t1_access_penable", {63'd0, penable}, 64'd1);
    @(negedge clock);
    chk("t1_rsp_valid", {62'd0, rsp_valid}, 64'd1);
    chk("t1_rsp_rdata", {32'd0, rsp_rdata}, 64'h0040_0C82);
    chk("t1_latency", 64'(cyc - t), 64'd3);
    chk("t1_psel_done", {63'd0, psel}, 64'd0);
    @(negedge clock);
    chk("t1_rsp_pulse", {62'd0, rsp_valid}, 64'd0);
    chk("t1_rdata_hold", {32'd0, rsp_rdata}, 64'h0040_0C82);
    chk("t1_paddr_hold", {32'd0, paddr}, {32'd0, 24'd0, DM_DMSTATUS});

    // Write from req1.
    @(posedge clock); #1 set_req(1, 1'b1, {24'd0, DM_DATA0}, 32'hDEAD_BEEF);
    @(negedge clock);
    chk("t3_ready", {62'd0, req_ready}, 64'd2);
    @(posedge clock); #1 req_valid[1] = 1'b0;
    @(negedge clock);
    chk("t3_setup_pwrite", {63'd0, pwrite}, 64'd1);
    chk("t3_setup_pwdata", {32'd0, pwdata}, 64'hDEAD_BEEF);
    @(negedge clock);
    chk("t3_access_paddr", {32'd0, paddr}, 64'h04);
    chk("t3_access_pwdata", {32'd0, pwdata}, 64'hDEAD_BEEF);
    @(negedge clock);
    chk("t3_rsp_valid", {62'd0, rsp_valid}, 64'd2);
    chk("t3_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
    chk("t3_rsp_err", {63'd0, rsp_err}, 64'd0);

    // Wait states: pready low for three ACCESS cycles, req1 waiting meanwhile.
    @(posedge clock); #1 set_req(0, 1'b0, {24'd0, DM_DMCONTROL}, 32'h0);
    @(negedge clock);
    chk("t4_ready", {62'd0, req_ready}, 64'd1);
    t = cyc;
    @(posedge clock); #1 req_valid[0] = 1'b0; pready = 1'b0;
    set_req(1, 1'b0, {24'd0, DM_DATA2}, 32'h0);
    @(negedge clock);
    chk("t4_setup_no_ready", {62'd0, req_ready}, 64'd0);
    for (int n = 0; n < 3; n++) begin
      @(negedge clock);
      chk("t4_wait_penable", {63'd0, penable}, 64'd1);
      chk("t4_wait_no_ready", {62'd0, req_ready}, 64'd0);
      chk("t4_wait_no_rsp", {62'd0, rsp_valid}, 64'd0);
    end
    @(posedge clock); #1 pready = 1'b1;
    @(negedge clock);
    chk("t4_last_access", {63'd0, penable}, 64'd1);
    chk("t4_last_no_ready", {62'd0, req_ready}, 64'd0);
    @(negedge clock);
    chk("t4_rsp_valid", {62'd0, rsp_valid}, 64'd1);
    chk("t4_latency", 64'(cyc - t), 64'd6);
    chk("t4_b2b_ready", {62'd0, req_ready}, 64'd2);
    @(posedge clock); #1 req_valid[1] = 1'b0;
    wait_drain();

    // Request withdrawn before it could be accepted.
    @(posedge clock); #1 set_req(0, 1'b0, {24'd0, DM_DATA3}, 32'h0);
    await_accept(0, acc);
    set_req(1, 1'b0, {24'd0, DM_DATA1}, 32'h0);
    @(posedge clock); #1 req_valid[1] = 1'b0;
    wait_drain();
    for (int n = 0; n < 3; n++) begin
      @(negedge clock);
      chk("drop_no_psel", {63'd0, psel}, 64'd0);
    end

    // Slave never ready.
    @(posedge clock); #1 pready = 1'b0;
`ifdef DM_ARB_TIMEOUT_EN
    expect_to = 1;
`endif
    set_req(0, 1'b0, {24'd0, DM_DMSTATUS}, 32'h0);
    await_accept(0, acc);
`ifdef DM_ARB_TIMEOUT_EN
    acc = 0; got = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clock);
      if (rsp_valid != 2'b00) begin got = 1; break; end
      if (penable) acc++;
    end
    chk("to_rsp_seen", {63'd0, got}, 64'd1);
    chk("to_access_cycles", 64'(acc), 64'd16);
    chk("to_err", {63'd0, rsp_err}, 64'd1);
    chk("to_rdata", {32'd0, rsp_rdata}, 64'd0);
    @(negedge clock);
    chk("to_idle", {63'd0, psel}, 64'd0);
    @(posedge clock); #1 pready = 1'b1; expect_to = 0;
`else
    got = 0;
    repeat (30) begin
      @(negedge clock);
      if (rsp_valid != 2'b00) got = 1;
    end
    chk("stall_no_rsp", {63'd0, got}, 64'd0);
    chk("stall_penable", {63'd0, penable}, 64'd1);
    @(posedge clock); #1 pready = 1'b1;
    @(negedge clock);
    chk("stall_still_access", {63'd0, penable}, 64'd1);
    @(negedge clock);
    chk("stall_rsp_valid", {62'd0, rsp_valid}, 64'd1);
    chk("stall_rsp_err", {63'd0, rsp_err}, 64'd0);
`endif
    wait_drain();

    // Reset in the middle of ACCESS.
    @(posedge clock); #1 pready = 1'b0;
    set_req(1, 1'b0, {24'd0, DM_DATA1}, 32'h0);
    await_accept(1, acc);
    @(negedge clock);
    @(negedge clock);
    chk("t6_in_access", {63'd0, penable}, 64'd1);
    #1 resetn = 1'b0; sb.delete(); model_last = 1'b1;
    #1;
    chk("t6_psel", {63'd0, psel}, 64'd0);
    chk("t6_penable", {63'd0, penable}, 64'd0);
    chk("t6_rsp_valid", {62'd0, rsp_valid}, 64'd0);
    @(posedge clock); #1 resetn = 1'b1; pready = 1'b1;
    set_req(0, 1'b0, {24'd0, DM_HARTINFO}, 32'h0);
    set_req(1, 1'b0, {24'd0, DM_COMMAND}, 32'h0);
    @(negedge clock);
    chk("t6_tie_req0", {62'd0, req_ready}, 64'd1);
    @(posedge clock); #1 req_valid = 2'b00;
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    chk("t6_rsp_req0", {62'd0, rsp_valid}, 64'd1);
    chk("t6_rsp_rdata", {32'd0, rsp_rdata}, {32'd0, slv_data(DM_HARTINFO)});
    repeat (4) begin
      @(negedge clock);
      chk("t6_no_stale", {62'd0, rsp_valid}, 64'd0);
    end
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
